// File: rtl/quad_enc.sv
// Quadrature pattern generator: emits a signed number of A/B edges at a
// programmable edge period and tracks the net edge count in position.
module quad_enc #(
  parameter int PERIOD_W = 16,
  parameter int STEPS_W  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic signed [STEPS_W-1:0]  cmd_steps,
  input  logic        [PERIOD_W-1:0] cmd_period,
  input  logic                       abort,
  output logic                       A,
  output logic                       B,
  output logic                       busy,
  output logic                       done,
  output logic signed [31:0]         position
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state_q, state_d;
  logic                a_q, a_d, b_q, b_d;
  logic signed [31:0]  pos_q, pos_d;
  logic [STEPS_W-1:0]  rem_q, rem_d;
  logic [PERIOD_W-1:0] timer_q, timer_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                rev_q, rev_d;
  logic                done_q, done_d;

  logic                accept;
  logic                steps_neg;
  logic [STEPS_W-1:0]  steps_u;
  logic [STEPS_W-1:0]  steps_mag;
  logic [PERIOD_W-1:0] period_eff;
  logic                edge_due;
  logic                done_evt;

  assign accept     = cmd_valid && (state_q == IDLE);
  assign steps_neg  = cmd_steps[STEPS_W-1];
  assign steps_u    = cmd_steps;
  // Unsigned negate keeps the most negative count representable as 2^(STEPS_W-1).
  assign steps_mag  = steps_neg ? -steps_u : steps_u;
  assign period_eff = (cmd_period == '0) ? PERIOD_W'(1) : cmd_period;
  assign edge_due   = (state_q == RUN) && (timer_q == PERIOD_W'(1));

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    pos_d    = pos_q;
    rem_d    = rem_q;
    timer_d  = timer_q;
    period_d = period_q;
    rev_d    = rev_q;
    done_evt = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (steps_mag == '0) begin
            done_evt = 1'b1;
          end else begin
            state_d  = RUN;
            rem_d    = steps_mag;
            timer_d  = period_eff;
            period_d = period_eff;
            rev_d    = steps_neg;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d  = IDLE;
          rem_d    = '0;
          timer_d  = '0;
          done_evt = 1'b1;
        end else if (edge_due) begin
          // Forward walks 00->10->11->01, reverse walks the opposite way.
          if (rev_q) begin
            a_d   = b_q;
            b_d   = ~a_q;
            pos_d = pos_q - 32'sd1;
          end else begin
            a_d   = ~b_q;
            b_d   = a_q;
            pos_d = pos_q + 32'sd1;
          end
          rem_d   = rem_q - STEPS_W'(1);
          timer_d = period_q;
          if (rem_q == STEPS_W'(1)) begin
            state_d  = IDLE;
            timer_d  = '0;
            done_evt = 1'b1;
          end
        end else begin
          timer_d = timer_q - PERIOD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A completion landing right after another one is folded into the
    // pulse already showing, so done is never high two cycles running.
    done_d = done_evt && !done_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      pos_q    <= '0;
      rem_q    <= '0;
      timer_q  <= '0;
      period_q <= '0;
      rev_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      pos_q    <= pos_d;
      rem_q    <= rem_d;
      timer_q  <= timer_d;
      period_q <= period_d;
      rev_q    <= rev_d;
      done_q   <= done_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign done      = done_q;
  assign A         = a_q;
  assign B         = b_q;
  assign position  = pos_q;

endmodule

// File: tb/tb_quad_enc.sv
// Directed bench for quad_enc: hand-computed AB phases, positions and
// handshake timing for forward, reverse, boundary, abort and reset cases.
module tb_quad_enc;

  logic               clk;
  logic               reset;
  logic               cmd_valid;
  logic               cmd_ready;
  logic signed [15:0] cmd_steps;
  logic        [15:0] cmd_period;
  logic               abort;
  logic               A;
  logic               B;
  logic               busy;
  logic               done;
  logic signed [31:0] position;

  int total;
  int bad;

  quad_enc #(.PERIOD_W(16), .STEPS_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_steps  (cmd_steps),
    .cmd_period (cmd_period),
    .abort      (abort),
    .A          (A),
    .B          (B),
    .busy       (busy),
    .done       (done),
    .position   (position)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic logic [31:0] ab();
    return {30'd0, A, B};
  endfunction

  // One clock; outputs are sampled 1 time unit after the rising edge.
  // Every cycle also checks the one-bit-per-edge and no-double-done rules.
  task automatic tick();
    logic [1:0] pab;
    logic       pd;
    logic       multi;
    pab = {A, B};
    pd  = done;
    @(posedge clk);
    #1;
    multi = (pab ^ {A, B}) == 2'b11;
    check("ab_single_bit", {31'd0, multi}, 32'd0);
    check("done_not_twice", {31'd0, pd & done}, 32'd0);
  endtask

  task automatic send(input int steps, input int period);
    cmd_valid  = 1'b1;
    cmd_steps  = 16'(steps);
    cmd_period = 16'(period);
    tick();
    cmd_valid  = 1'b0;
  endtask

  logic [1:0] fwd_exp [4];
  logic [1:0] rev_exp [6];
  int n;

  initial begin
    total = 0;
    bad   = 0;
    fwd_exp = '{2'b10, 2'b11, 2'b01, 2'b00};
    rev_exp = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11};

    reset      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_steps  = '0;
    cmd_period = '0;
    abort      = 1'b0;

    // Reset state, visible before any clock edge.
    #1;
    check("rst_ab", ab(), 32'd0);
    check("rst_pos", position, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;

    // Forward +4 at period 3: edges at +3,+6,+9,+12; cmd changes mid-run ignored.
    send(4, 3);
    check("fwd_busy", {31'd0, busy}, 32'd1);
    check("fwd_ready", {31'd0, cmd_ready}, 32'd0);
    cmd_valid  = 1'b1;
    cmd_steps  = -16'sd7;
    cmd_period = 16'd1;
    tick();
    check("fwd_hold1", ab(), 32'd0);
    tick();
    cmd_valid = 1'b0;
    check("fwd_hold2", ab(), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("fwd_ab", ab(), {30'd0, fwd_exp[k]});
      check("fwd_pos", position, 32'(k + 1));
      if (k < 3) begin
        tick();
        tick();
      end
    end
    check("fwd_done", {31'd0, done}, 32'd1);
    check("fwd_idle", {31'd0, busy}, 32'd0);
    check("fwd_ready_end", {31'd0, cmd_ready}, 32'd1);
    tick();
    check("fwd_done_drop", {31'd0, done}, 32'd0);

    // Reverse -6 at period 1 from AB=00: one edge per cycle.
    send(-6, 1);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("rev_ab", ab(), {30'd0, rev_exp[k]});
      check("rev_pos", position, 32'(4 - (k + 1)));
    end
    check("rev_done", {31'd0, done}, 32'd1);
    tick();

    // Period 0 acts as period 1; phase continues from AB=11 forward.
    send(2, 0);
    tick();
    check("p0_ab1", ab(), 32'b01);
    check("p0_pos1", position, -32'sd1);
    tick();
    check("p0_ab2", ab(), 32'b00);
    check("p0_pos2", position, 32'd0);
    check("p0_done", {31'd0, done}, 32'd1);
    tick();

    // Zero steps: done the cycle after acceptance, nothing moves.
    send(0, 5);
    check("zero_done", {31'd0, done}, 32'd1);
    check("zero_busy", {31'd0, busy}, 32'd0);
    check("zero_ab", ab(), 32'd0);
    check("zero_pos", position, 32'd0);
    tick();
    check("zero_done_drop", {31'd0, done}, 32'd0);

    // Abort in IDLE alongside a command: ignored, command accepted.
    abort = 1'b1;
    send(100, 2);
    abort = 1'b0;
    check("abort_idle_acc", {31'd0, busy}, 32'd1);
    for (int k = 0; k < 9; k++) tick();
    check("abort_pre_pos", position, 32'd4);
    // Abort in the cycle the 5th edge is due.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_pos", position, 32'd4);
    check("abort_ab", ab(), 32'd0);
    check("abort_done", {31'd0, done}, 32'd1);
    check("abort_ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    check("abort_done_drop", {31'd0, done}, 32'd0);
    check("abort_pos_hold", position, 32'd4);

    // Most negative step count: exactly 32768 reverse edges.
    send(-32768, 1);
    n = 0;
    while (!done && n < 40000) begin
      tick();
      n++;
    end
    check("negmax_cycles", n, 32'd32768);
    check("negmax_pos", position, 32'(4 - 32768));
    check("negmax_ab", ab(), 32'd0);
    tick();

    // Async reset between edges mid-run.
    send(10, 1);
    tick();
    tick();
    tick();
    check("mid_pos", position, 32'(4 - 32768 + 3));
    check("mid_ab", ab(), 32'b01);
    #3 reset = 1'b0;
    #1;
    check("arst_ab", ab(), 32'd0);
    check("arst_pos", position, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    check("arst_no_done", {31'd0, done}, 32'd0);
    #2 reset = 1'b1;

    // First edge after release accepts a command.
    send(1, 1);
    check("post_rst_acc", {31'd0, busy}, 32'd1);
    tick();
    check("post_rst_ab", ab(), 32'b10);
    check("post_rst_pos", position, 32'd1);
    check("post_rst_done", {31'd0, done}, 32'd1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
